// File: rtl/bakery_counter_scheduler.sv
// bakery_counter_scheduler: take-a-number arbiter for one bakery counter.
// Customers draw tickets, are served in ticket order through ORDER/BAKE.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   take[N]           per-customer ticket request pulse
//   waiting[N]        customer holds an unserved ticket
//   grant[N]          one-hot handoff pulse (HANDOFF state)
//   serving_id        customer in service (valid while busy)
//   now_serving       ticket of current/next served customer
//   next_ticket       ticket the next accepted take receives
//   queue_len         tickets issued, not yet popped
//   busy, b, p, s     state decodes: !IDLE, ORDER, BAKE, state code
module bakery_counter_scheduler #(
  parameter int N         = 4,
  parameter int TW        = 4,
  parameter int ORDER_CYC = 2,
  parameter int BAKE_CYC  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         take,
  output logic [N-1:0]         waiting,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] serving_id,
  output logic [TW-1:0]        now_serving,
  output logic [TW-1:0]        next_ticket,
  output logic [$clog2(N):0]   queue_len,
  output logic                 busy,
  output logic                 b,
  output logic                 p,
  output logic [1:0]           s
);

  localparam int IW = $clog2(N);
  localparam int QW = IW + 1;
  localparam int MX = (ORDER_CYC > BAKE_CYC) ?
                      ORDER_CYC : BAKE_CYC;
  localparam int CW = $clog2(MX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ORDER = 2'b01,
    ST_BAKE  = 2'b10,
    ST_HAND  = 2'b11
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_phase;
  logic [CW-1:0] w_phase_nx;
  logic          w_pop;
  logic          w_done;

  logic [N-1:0]  r_waiting;
  logic [N-1:0]  w_accept;
  logic [N-1:0]  w_sid_oh;
  logic [N-1:0]  w_clr;
  logic [IW-1:0] r_fifo    [N];
  logic [IW-1:0] w_fifo_nx [N];
  logic [QW-1:0] r_qlen;
  logic [QW-1:0] w_qlen_nx;
  logic [IW-1:0] r_sid;
  logic [TW-1:0] r_now;
  logic [TW-1:0] r_next;
  logic [TW-1:0] w_next_nx;

  // Phase counter counts down to zero; it is reloaded on each state entry.
  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_pop      = 1'b0;
    w_done     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_qlen != '0) begin
          w_pop      = 1'b1;
          w_state_nx = ST_ORDER;
          w_phase_nx = CW'(ORDER_CYC - 1);
        end
      end
      ST_ORDER: begin
        if (r_phase == '0) begin
          w_state_nx = ST_BAKE;
          w_phase_nx = CW'(BAKE_CYC - 1);
        end else begin
          w_phase_nx = r_phase - CW'(1);
        end
      end
      ST_BAKE: begin
        if (r_phase == '0) begin
          w_state_nx = ST_HAND;
          w_phase_nx = '0;
        end else begin
          w_phase_nx = r_phase - CW'(1);
        end
      end
      ST_HAND: begin
        w_done     = 1'b1;
        w_state_nx = ST_IDLE;
        w_phase_nx = '0;
      end
    endcase
  end

  // Shift-register queue with head at slot 0. Pop shifts first, then
  // accepted takes append in ascending index order, so FIFO order is
  // ticket order.
  always_comb begin
    w_accept  = take & ~r_waiting;
    w_fifo_nx = r_fifo;
    w_qlen_nx = r_qlen;
    w_next_nx = r_next;
    if (w_pop) begin
      for (int j = 0; j < N - 1; j++)
        w_fifo_nx[j] = r_fifo[j+1];
      w_qlen_nx = r_qlen - QW'(1);
    end
    for (int i = 0; i < N; i++) begin
      if (w_accept[i]) begin
        if (w_qlen_nx < QW'(N))
          w_fifo_nx[w_qlen_nx[IW-1:0]] = IW'(i);
        w_qlen_nx = w_qlen_nx + QW'(1);
        w_next_nx = w_next_nx + TW'(1);
      end
    end
  end

  assign w_sid_oh = N'(1) << r_sid;
  assign w_clr    = w_done ? w_sid_oh : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_phase   <= '0;
      r_waiting <= '0;
      r_qlen    <= '0;
      r_sid     <= '0;
      r_now     <= '0;
      r_next    <= '0;
      for (int j = 0; j < N; j++)
        r_fifo[j] <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_phase   <= w_phase_nx;
      r_waiting <= (r_waiting & ~w_clr) | w_accept;
      r_qlen    <= w_qlen_nx;
      r_next    <= w_next_nx;
      r_fifo    <= w_fifo_nx;
      if (w_pop)
        r_sid <= r_fifo[0];
      if (w_done)
        r_now <= r_now + TW'(1);
    end
  end

  assign waiting     = r_waiting;
  assign grant       = (r_state == ST_HAND) ? w_sid_oh : '0;
  assign serving_id  = r_sid;
  assign now_serving = r_now;
  assign next_ticket = r_next;
  assign queue_len   = r_qlen;
  assign busy        = (r_state != ST_IDLE);
  assign b           = (r_state == ST_ORDER);
  assign p           = (r_state == ST_BAKE);
  assign s           = r_state;

endmodule
